// File: rtl/cache_cmp.sv
// rtl/cache_cmp.sv - read-only cache compare stage: hit check, line-fill FSM, array write strobes
package cache_cmp_pkg;
    typedef struct packed {
        logic [31:0] mem_address;
        logic        mem_read;
        logic        mem_write;
        logic [3:0]  mem_byte_enable;
        logic [31:0] mem_wdata;
        logic [3:0]  set;
        logic [22:0] tag;
    } caac_fwd;
endpackage

module cache_cmp
    import cache_cmp_pkg::*;
#(
    parameter int SET_BITS = 4,
    parameter int TAG_BITS = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  caac_fwd       caac_i,
    input  logic [255:0]  data_i,
    input  logic [23:0]   tag_i,
    input  logic          valid_i,
    input  logic          pmem_resp,
    output logic [31:0]   mem_rdata,
    output logic          mem_resp,
    output logic [31:0]   pmem_address,
    output logic          pmem_read,
    output logic          data_web,
    output logic          tag_web,
    output logic          valid_web,
    output logic          stall
);
    localparam int OFFSET_BITS = 32 - TAG_BITS - SET_BITS;

    typedef enum logic [1:0] {S_CMP, S_FILL, S_WRITE, S_REREAD} state_t;

    state_t  r_state;
    state_t  w_next;
    caac_fwd r_req;
    logic    r_req_valid;
    logic    w_hit;
    logic    w_stall;
    logic [2:0]  w_k;
    logic [31:0] w_word;
    logic    w_unused;

    // Request register: frozen while stalled so the arrays keep returning the same set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req       <= '0;
            r_req_valid <= 1'b0;
        end else if (!w_stall) begin
            r_req       <= caac_i;
            r_req_valid <= caac_i.mem_read & ~caac_i.mem_write;
        end
    end

    assign w_hit  = r_req_valid & valid_i & (tag_i[TAG_BITS-1:0] == r_req.tag);
    assign w_k    = r_req.mem_address[4:2];
    assign w_word = data_i[{w_k, 5'b0} +: 32];
    assign w_stall = (r_state != S_CMP) | (r_req_valid & ~w_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_CMP;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CMP:    if (r_req_valid && !w_hit) w_next = S_FILL;
            S_FILL:   if (pmem_resp) w_next = S_WRITE;
            S_WRITE:  w_next = S_REREAD;
            S_REREAD: w_next = S_CMP;
            default:  w_next = S_CMP;
        endcase
    end

    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_address = '0;
        pmem_read    = 1'b0;
        data_web     = 1'b0;
        tag_web      = 1'b0;
        valid_web    = 1'b0;
        stall        = w_stall;
        case (r_state)
            S_CMP: begin
                mem_resp = w_hit;
                if (w_hit) mem_rdata = w_word;
            end
            S_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {r_req.tag, r_req.set, {OFFSET_BITS{1'b0}}};
            end
            S_WRITE: begin
                data_web  = 1'b1;
                tag_web   = 1'b1;
                valid_web = 1'b1;
            end
            default: ;
        endcase
    end

    // Write data/byte enables ride along for a future write path; tag bit 23 is never compared.
    assign w_unused = ^{r_req.mem_address[31:5], r_req.mem_address[1:0], r_req.mem_read,
                        r_req.mem_write, r_req.mem_byte_enable, r_req.mem_wdata, tag_i[23]};
endmodule

// File: tb/tb_cache_cmp.sv
// tb/tb_cache_cmp.sv - randomized and directed bench for cache_cmp with array/pmem environment
module tb_cache_cmp;
    import cache_cmp_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    caac_fwd      caac;
    logic [255:0] data_i;
    logic [23:0]  tag_i;
    logic         valid_i;
    logic         pmem_resp;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         data_web, tag_web, valid_web;
    logic         stall;

    int n_checks = 0;
    int n_fail   = 0;

    cache_cmp #(.SET_BITS(4), .TAG_BITS(23)) dut (
        .clk(clk), .rst(rst), .caac_i(caac),
        .data_i(data_i), .tag_i(tag_i), .valid_i(valid_i), .pmem_resp(pmem_resp),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read),
        .data_web(data_web), .tag_web(tag_web), .valid_web(valid_web),
        .stall(stall)
    );

    always #5 clk = ~clk;

    // Backing memory content: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w ^ 32'h5A5A_0F0F) * 32'h9E37_79B1 + 32'h0101_0101;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = mem_word({a[31:5], 5'b0} + 32'(4*i));
        return l;
    endfunction

    // Environment: the calc stage's arrays and set register, plus pmem fill capture.
    logic [255:0] env_data [16];
    logic [23:0]  env_tag  [16];
    logic         env_valid[16];
    logic [3:0]   env_set;
    logic [31:0]  fill_addr;

    assign data_i  = env_data[env_set];
    assign tag_i   = env_tag[env_set];
    assign valid_i = env_valid[env_set];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            env_set <= '0;
        end else begin
            if (!stall) env_set <= caac.set;
            if (pmem_read) fill_addr <= pmem_address;
            if (data_web) env_data[env_set] <= line_of(fill_addr);
            if (tag_web) env_tag[env_set] <= {1'b0, fill_addr[31:9]};
            if (valid_web) env_valid[env_set] <= 1'b1;
        end
    end

    // Reference model: which tag each set holds after the requests issued so far.
    bit          m_valid[16];
    logic [22:0] m_tag[16];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] strobes();
        return {29'b0, data_web, tag_web, valid_web};
    endfunction

    task automatic drive_req(input logic [31:0] addr, input bit wr);
        caac.mem_address     = addr;
        caac.mem_read        = !wr;
        caac.mem_write       = wr;
        caac.mem_byte_enable = 4'($urandom);
        caac.mem_wdata       = $urandom;
        caac.set             = addr[8:5];
        caac.tag             = addr[31:9];
    endtask

    task automatic drive_idle();
        caac = '0;
    endtask

    // Called at a negedge; presents the request and follows it to completion.
    task automatic do_read(input logic [31:0] addr, input bit wr, input int fill_lat);
        bit exp_hit;
        exp_hit = m_valid[addr[8:5]] && (m_tag[addr[8:5]] == addr[31:9]);
        drive_req(addr, wr);
        @(negedge clk);
        if (wr) begin
            chk("wr_stall", stall, 0);
            chk("wr_resp", mem_resp, 0);
            chk("wr_pmem_read", pmem_read, 0);
            chk("wr_strobes", strobes(), 0);
            drive_idle();
            @(negedge clk);
            chk("wr_pmem_read_after", pmem_read, 0);
            chk("wr_strobes_after", strobes(), 0);
            return;
        end
        if (exp_hit) begin
            chk("hit_resp", mem_resp, 1);
            chk("hit_stall", stall, 0);
            chk("hit_rdata", mem_rdata, mem_word(addr));
            chk("hit_pmem_read", pmem_read, 0);
            drive_idle();
            return;
        end
        chk("miss_stall", stall, 1);
        chk("miss_resp", mem_resp, 0);
        for (int c = 0; c < fill_lat; c++) begin
            @(negedge clk);
            chk("fill_pmem_read", pmem_read, 1);
            chk("fill_pmem_addr", pmem_address, {addr[31:5], 5'b0});
            chk("fill_stall", stall, 1);
            chk("fill_strobes", strobes(), 0);
            if (c == fill_lat - 1) pmem_resp = 1'b1;
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        chk("write_strobes", strobes(), 3'b111);
        chk("write_stall", stall, 1);
        chk("write_pmem_read", pmem_read, 0);
        @(negedge clk);
        chk("reread_strobes", strobes(), 0);
        chk("reread_stall", stall, 1);
        chk("reread_resp", mem_resp, 0);
        @(negedge clk);
        chk("post_fill_resp", mem_resp, 1);
        chk("post_fill_rdata", mem_rdata, mem_word(addr));
        chk("post_fill_stall", stall, 0);
        m_valid[addr[8:5]] = 1'b1;
        m_tag[addr[8:5]]   = addr[31:9];
        drive_idle();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_resp"}, mem_resp, 0);
        chk({name, "_rdata"}, mem_rdata, 0);
        chk({name, "_paddr"}, pmem_address, 0);
        chk({name, "_pread"}, pmem_read, 0);
        chk({name, "_stall"}, stall, 0);
        chk({name, "_strobes"}, strobes(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b2b[4];
        logic [31:0] a;
        rst = 1'b0;
        pmem_resp = 1'b0;
        drive_idle();
        for (int i = 0; i < 16; i++) begin
            env_valid[i] = 1'b0;
            env_tag[i]   = 24'($urandom);
            for (int j = 0; j < 8; j++) env_data[i][32*j +: 32] = $urandom;
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        repeat (2) @(negedge clk);
        chk_all_zero("reset");

        // Cold miss; request presented on the first edge after release.
        rst = 1'b1;
        do_read(32'h0000_1234, 1'b0, 3);
        do_read(32'h0000_1228, 1'b0, 1);
        do_read(32'h0000_3234, 1'b0, 2);
        do_read(32'h0000_1234, 1'b0, 1);

        // Back-to-back hits on the refilled line.
        b2b[0] = 32'h0000_1220; b2b[1] = 32'h0000_1224;
        b2b[2] = 32'h0000_1228; b2b[3] = 32'h0000_123C;
        drive_req(b2b[0], 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_resp", mem_resp, 1);
            chk("b2b_rdata", mem_rdata, mem_word(b2b[i]));
            chk("b2b_stall", stall, 0);
            if (i < 3) drive_req(b2b[i+1], 1'b0);
            else drive_idle();
        end

        // Write request is dropped.
        do_read(32'h0000_1234, 1'b1, 1);

        // Reset mid-fill, then a stray pmem_resp.
        drive_req(32'h0000_5444, 1'b0);
        @(negedge clk);
        chk("rstfill_miss_stall", stall, 1);
        repeat (3) begin
            @(negedge clk);
            chk("rstfill_pmem_read", pmem_read, 1);
        end
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid_fill");
        drive_idle();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk_all_zero("in_reset");
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("stray_pmem_resp");
        pmem_resp = 1'b0;
        @(negedge clk);
        chk_all_zero("after_abort");
        do_read(32'h0000_5444, 1'b0, 2);

        // Pmem_resp outside FILL is ignored.
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        chk_all_zero("idle_pmem_resp");

        // Randomized mix of reads (small tag range to force hits and conflicts) and writes.
        for (int n = 0; n < 60; n++) begin
            a = {21'($urandom_range(0, 3)), 2'b0, 4'($urandom_range(0, 15)), 3'($urandom), 2'b00};
            do_read(a, $urandom_range(0, 7) == 0, $urandom_range(1, 4));
        end
        @(negedge clk);
        chk_all_zero("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_cmp.md
CACHE_CMP -- requirements
Module: cache_cmp

Interface
REQ-001 SHALL have parameter SET_BITS, default 4, number of set-index bits.
REQ-002 SHALL have parameter TAG_BITS, default 23, number of address tag bits; the tag array width is 24, and bit 23 is written 0 and ignored on compare.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port caac_i  in  caac_fwd  request fields from calc stage: mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, set, tag.
REQ-006 SHALL have ports data_i  in  256, tag_i  in  24, valid_i  in  1; these are the array read data for the set held by the calc stage.
REQ-007 SHALL have port pmem_resp  in  1  physical memory line-read complete.
REQ-008 SHALL have ports mem_rdata  out  32 and mem_resp  out  1, the CPU-side read word and completion.
REQ-009 SHALL have ports pmem_address  out  32 and pmem_read  out  1, the line-fill request.
REQ-010 SHALL have ports data_web, tag_web, valid_web  out  1 each, active-high array write strobes to calc.
REQ-011 SHALL have port stall  out  1, which holds calc on its previous request and set.

Function
REQ-012 SHALL capture caac_i into request register req, and set req_valid = caac_i.mem_read, on a rising edge where stall=0.
REQ-013 SHALL hold req and req_valid unchanged while stall=1.
REQ-014 SHALL implement the states CMP, FILL, WRITE and REREAD.
REQ-015 SHALL define hit = req_valid & valid_i & (tag_i[22:0] == req.tag).
REQ-016 CMP, hit: SHALL drive mem_resp=1 and mem_rdata = data_i[32*k +: 32] with k = req.mem_address[4:2], all combinationally, and SHALL remain in CMP.
REQ-017 CMP, req_valid & ~hit: SHALL set stall=1 combinationally, drive mem_resp=0, and go to FILL.
REQ-018 CMP, ~req_valid: SHALL drive mem_resp=0 and stall=0.
REQ-019 FILL: SHALL drive pmem_read=1, pmem_address = {req.tag, req.set, 5'b0} and stall=1; go to WRITE on pmem_resp=1, otherwise stay in FILL.
REQ-020 FILL SHALL last at least one cycle; pmem_resp is ignored outside FILL.
REQ-021 WRITE: SHALL pulse data_web, tag_web and valid_web all =1 for exactly one cycle, with stall=1 and pmem_read=0; next state is REREAD.
REQ-022 REREAD: SHALL drive stall=1 for one cycle so the arrays return the updated line; next state is CMP, where hit is then guaranteed.
REQ-023 SHALL set stall = (state != CMP) | (state == CMP & req_valid & ~hit).
REQ-024 Miss latency SHALL be: miss cycle, FILL cycles to pmem_resp, 1 WRITE cycle, 1 REREAD cycle, then the hit cycle with mem_resp.
REQ-025 Hit latency SHALL be: mem_resp in the cycle after calc presents the request.
REQ-026 Requests with mem_write=1 SHALL NOT be serviced; req_valid=0 for them, and they produce no pmem or array activity (read-only cache).
REQ-027 mem_byte_enable and mem_wdata SHALL be carried in req but SHALL be unused.
REQ-028 Write strobes SHALL be 0 in all states except WRITE; pmem_read SHALL be 0 in all states except FILL.
REQ-029 Back-to-back hits SHALL sustain one mem_resp per cycle with stall=0.

Reset
REQ-030 rst=0 SHALL asynchronously force state=CMP, req='0 and req_valid=0.
REQ-031 Under reset, all outputs SHALL be 0, including mem_rdata, pmem_address, pmem_read, stall and the write strobes.
REQ-032 Reset asserted in FILL, WRITE or REREAD SHALL abort the fill, with no array write and no mem_resp; a pmem_resp arriving after reset SHALL be ignored.
REQ-033 After rst release, the first request SHALL be accepted on the first rising edge.

Verification
REQ-034 Cold miss, read 0x0000_1234 with all valid=0 -> pmem_read=1 and pmem_address=0x0000_1220; after pmem_resp, one WRITE cycle with all strobes 1, one REREAD cycle, then mem_resp=1 with word k=5.
REQ-035 Hit after fill, read 0x0000_1228 -> mem_resp=1 in the next cycle, word k=2, stall=0, pmem_read never asserted.
REQ-036 Conflict, read 0x0000_3234 (same set 1, different tag) -> miss, pmem_address=0x0000_3220, line replaced; a subsequent read of 0x0000_1234 misses again.
REQ-037 Reset asserted mid-FILL after 3 cycles, then pmem_resp pulsed -> no strobes, no mem_resp, state CMP, and the set is still invalid on a later read.
REQ-038 Write request, mem_write=1 to 0x0000_1234 -> no pmem_read, no strobes, stall=0, mem_resp=0.
REQ-039 Four back-to-back hits to the same line at word offsets 0, 4, 8 and 0x1C -> four consecutive mem_resp cycles with the correct words and stall constantly 0.
